ats_alarm_event_queue: RTL and testbench
========================================

Name: ats_alarm_event_queue

Overview:
- Downstream consumer of the alarm timer's 24-bit `data` bus, where each bit is an alarm "finished" flag held high for 2 cycles per expiry.
- Converts each finished-bit rising edge into one queued event carrying the alarm index.
- Client drains events through a valid/ready handshake; lost events flag a sticky overflow.

Parameters:
NUM_ALARMS, 24, number of alarm finished inputs
FIFO_DEPTH, 8, event queue entries (power of 2, >=2)
IDX_W, $clog2(NUM_ALARMS), width of alarm index
CNT_W, $clog2(FIFO_DEPTH)+1, width of occupancy count

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
alarm_finished  input  NUM_ALARMS  finished flags from alarm timer data bus
alarm_mask  input  NUM_ALARMS  1 = alarm may generate events
evt_valid  output  1  queue head holds an event
evt_ready  input  1  client accepts head this cycle
evt_index  output  IDX_W  alarm index of head event
evt_time  output  16  timestamp of head event (see Optional Feature)
evt_count  output  CNT_W  entries currently in queue
pending  output  NUM_ALARMS  detected edges not yet enqueued
overflow  output  1  sticky: an event was lost
clear_overflow  input  1  clears overflow

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: evt_valid=0, evt_index=0, evt_time=0, evt_count=0, pending=0, overflow=0.
  - FIFO pointers = 0.
  - prev register loads alarm_finished, so a flag already high at reset release produces no event.
- Edge detect, every cycle: rise = alarm_finished & ~prev & alarm_mask; then prev <= alarm_finished.
  - A 2-cycle-high flag yields exactly one rise.
- Pending update at posedge: pending <= (pending & ~enq_onehot) | rise.
  - A rise on a bit being enqueued the same cycle leaves that bit set (new event kept).
  - A rise on a bit already pending and not being enqueued: overflow <= 1 (coalesced, event lost).
- Enqueue selection:
  - If pending != 0 and the FIFO can accept (count < FIFO_DEPTH, or a pop occurs this cycle), push the lowest-index set pending bit and clear it in that same cycle.
  - At most one push per cycle.
- Latency: finished rises sampled at edge k -> pending bit set at edge k -> pushed at edge k+1 -> evt_valid high after edge k+1 if the queue was empty (2 cycles).
- Queue: first-word fall-through.
  - evt_valid = (count != 0).
  - evt_index/evt_time show the head entry, stable while evt_valid && !evt_ready.
- Pop: occurs when evt_valid && evt_ready; the head advances at the posedge.
  - evt_ready while empty is ignored.
- Simultaneous push and pop: count unchanged; allowed when full (pop frees the slot).
- Full with no pop: pending bits hold; no loss unless that same alarm rises again (then overflow).
- Pointer wrap: pointers wrap modulo FIFO_DEPTH; count is the only full/empty source.
- Masking: clearing a mask bit blocks new rises only; already-pending bits still enqueue.
- clear_overflow: overflow <= 0, but a new loss in the same cycle wins (overflow stays 1).
- evt_count: reflects the post-edge value.

Optional Feature:
ATS_EVT_TIMESTAMP_EN
- Defined:
  - Adds a 16-bit free-running cycle counter, reset to 0, wrapping 0xFFFF->0.
  - Each push stores the counter value alongside the index; evt_time shows the head's stored value.
- Undefined:
  - No counter and no timestamp storage.
  - evt_time tied to 0.

Test Plan:
- Reset with alarm_finished=0x000001 held high -> after reset release no event; evt_count=0, pending=0.
- Bit 5 high for 2 cycles at edge 10 -> pending[5] set after edge 10; evt_valid=1 with evt_index=5 after edge 11; evt_ready=1 pops, evt_count returns to 0.
- Bits 3, 0 and 20 rise in the same cycle -> events pop in order 0, 3, 20, one per cycle, with evt_ready held 1.
- FIFO_DEPTH=8, evt_ready=0, alarms 0..9 rise in the same cycle:
  - Queue fills with 0..7; pending = bits 8,9; evt_count=8; overflow=0.
  - Bit 8 rises again -> overflow=1.
  - clear_overflow -> 0.
- Full queue with evt_ready=1 and pending[9] set -> pop and push in the same cycle; evt_count stays 8; 9 appears at the tail.
- With ATS_EVT_TIMESTAMP_EN, bit 2 rises at cycle 100 -> evt_time = 101 (the push cycle). Without the macro -> evt_time = 0.

Source files
------------

// File: rtl/ats_alarm_event_queue.sv
// Turns alarm "finished" rising edges into queued index events drained by valid/ready.
// Optional ATS_EVT_TIMESTAMP_EN stores a 16-bit push-cycle timestamp with each event.
module ats_alarm_event_queue #(
    parameter int NUM_ALARMS = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = $clog2(NUM_ALARMS),
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_ALARMS-1:0] alarm_finished,
    input  logic [NUM_ALARMS-1:0] alarm_mask,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [IDX_W-1:0]      evt_index,
    output logic [15:0]           evt_time,
    output logic [CNT_W-1:0]      evt_count,
    output logic [NUM_ALARMS-1:0] pending,
    output logic                  overflow,
    input  logic                  clear_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_ALARMS-1:0] prev, rise, enq_onehot, enq_clr;
    logic [IDX_W-1:0]      enq_idx;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [IDX_W-1:0]      idx_mem [FIFO_DEPTH];
    logic                  pop, push, loss;

    assign rise      = alarm_finished & ~prev & alarm_mask;
    assign evt_valid = (count != '0);
    assign evt_count = count;
    assign pop       = evt_valid & evt_ready;
    assign push      = (pending != '0) && ((count < CNT_W'(FIFO_DEPTH)) || pop);
    assign enq_clr   = push ? enq_onehot : '0;
    // A rise on a bit that stays pending this cycle coalesces and loses an event.
    assign loss      = |(rise & pending & ~enq_clr);

    // Lowest-index pending bit wins: scan downward, last hit is the lowest.
    always_comb begin
        enq_idx    = '0;
        enq_onehot = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                enq_idx    = IDX_W'(i);
                enq_onehot = NUM_ALARMS'(1) << i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= alarm_finished;
            pending  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            prev    <= alarm_finished;
            pending <= (pending & ~enq_clr) | rise;
            if (loss)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            idx_mem[wr_ptr] <= enq_idx;
    end

    assign evt_index = evt_valid ? idx_mem[rd_ptr] : '0;

`ifdef ATS_EVT_TIMESTAMP_EN
    logic [15:0] ts;
    logic [15:0] time_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (reset)
            ts <= '0;
        else
            ts <= ts + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            time_mem[wr_ptr] <= ts;
    end

    assign evt_time = evt_valid ? time_mem[rd_ptr] : '0;
`else
    assign evt_time = '0;
`endif

endmodule

// File: tb/tb_ats_alarm_event_queue.sv
// Randomized scoreboard bench for ats_alarm_event_queue against a queue-based reference model.
module tb_ats_alarm_event_queue;
    localparam int NA    = 24;
    localparam int DEPTH = 8;
    localparam int IW    = $clog2(NA);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NA-1:0] alarm_finished, alarm_mask, pending;
    logic          evt_valid, evt_ready, overflow, clear_overflow;
    logic [IW-1:0] evt_index;
    logic [15:0]   evt_time;
    logic [CW-1:0] evt_count;

    ats_alarm_event_queue #(.NUM_ALARMS(NA), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .alarm_finished(alarm_finished), .alarm_mask(alarm_mask),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
        .evt_time(evt_time), .evt_count(evt_count), .pending(pending),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int t; } ev_t;

    int tests = 0, fails = 0;
    bit started = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_t(input int t);
`ifdef ATS_EVT_TIMESTAMP_EN
        return t;
`else
        return 0;
`endif
    endfunction

    // Reference model: events live in a plain queue; popped events go to the scoreboard.
    bit [NA-1:0] m_prev, m_pend, m_r;
    bit          m_ovf;
    int          m_cyc, m_sel;
    ev_t         mq[$], sb[$];
    ev_t         m_e;

    always @(posedge clk) begin
        if (reset) begin
            m_prev = alarm_finished;
            m_pend = '0;
            m_ovf  = 0;
            mq.delete();
            m_cyc  = 0;
        end else begin
            m_r = alarm_finished & ~m_prev & alarm_mask;
            if (mq.size() > 0 && evt_ready)
                sb.push_back(mq.pop_front());
            m_sel = -1;
            for (int i = 0; i < NA; i++)
                if (m_pend[i] && m_sel < 0) m_sel = i;
            if (m_sel >= 0 && mq.size() < DEPTH) begin
                m_e.idx = m_sel;
                m_e.t   = m_cyc;
                mq.push_back(m_e);
                m_pend[m_sel] = 1'b0;
            end
            if ((m_r & m_pend) != '0)
                m_ovf = 1;
            else if (clear_overflow)
                m_ovf = 0;
            m_pend = m_pend | m_r;
            m_prev = alarm_finished;
            m_cyc  = (m_cyc + 1) & 16'hFFFF;
        end
    end

    // Monitor: a handshake seen at one negedge is scored at the next, after the model popped it.
    bit  hs_prev = 0;
    int  h_idx, h_time;
    ev_t s_e;

    always @(negedge clk) begin
        if (started) begin
            if (hs_prev) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    s_e = sb.pop_front();
                    chk("pop_index", h_idx, s_e.idx);
                    chk("pop_time", h_time, exp_t(s_e.t));
                end
            end
            hs_prev = !reset && evt_valid && evt_ready;
            h_idx   = evt_index;
            h_time  = evt_time;
            chk("evt_count", evt_count, mq.size());
            chk("evt_valid", evt_valid, mq.size() != 0);
            chk("pending", pending, m_pend);
            chk("overflow", overflow, m_ovf);
            if (mq.size() > 0)
                chk("head_index", evt_index, mq[0].idx);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int hold[NA];
    int rdy_pct;

    initial begin
        reset = 1; alarm_finished = 24'h000001; alarm_mask = '1;
        evt_ready = 0; clear_overflow = 0;
        repeat (3) @(posedge clk);
        #1 started = 1;
        reset = 0;
        step(3);
        chk("rst_count", evt_count, 0);
        chk("rst_pending", pending, 0);
        chk("rst_valid", evt_valid, 0);
        alarm_finished = '0;
        step(2);

        // Single alarm, 2-cycle pulse, 2-cycle latency to valid.
        alarm_finished = 24'h000020;
        step(1);
        chk("b5_pending", pending, 24'h000020);
        chk("b5_valid_early", evt_valid, 0);
        step(1);
        alarm_finished = '0;
        chk("b5_valid", evt_valid, 1);
        chk("b5_index", evt_index, 5);
        evt_ready = 1;
        step(1);
        chk("b5_drained", evt_count, 0);

        // Three simultaneous rises drain lowest index first.
        alarm_finished = (24'h1 << 3) | 24'h1 | (24'h1 << 20);
        step(1);
        step(1);
        alarm_finished = '0;
        chk("ord0", evt_index, 0);
        step(1);
        chk("ord3", evt_index, 3);
        step(1);
        chk("ord20", evt_index, 20);
        step(1);
        chk("ord_empty", evt_count, 0);

        // Fill the queue, overflow on a coalesced rise, then clear it.
        evt_ready = 0;
        alarm_finished = 24'h0003FF;
        step(2);
        alarm_finished = '0;
        step(7);
        chk("full_count", evt_count, 8);
        chk("full_pending", pending, 24'h000300);
        chk("full_ovf", overflow, 0);
        alarm_finished = 24'h000100;
        step(1);
        chk("ovf_set", overflow, 1);
        step(1);
        alarm_finished = '0;
        clear_overflow = 1;
        step(1);
        clear_overflow = 0;
        chk("ovf_clr", overflow, 0);
        evt_ready = 1;
        step(2);
        chk("full_pushpop_count", evt_count, 8);
        chk("full_pushpop_pending", pending, 0);
        step(12);
        chk("full_drained", evt_count, 0);

        // Randomized phases with varying drain rate, masking, clears and resets.
        for (int p = 0; p < 4; p++) begin
            rdy_pct = (p == 0) ? 90 : (p == 1) ? 20 : (p == 2) ? 60 : 5;
            for (int c = 0; c < 600; c++) begin
                for (int i = 0; i < NA; i++) begin
                    if (hold[i] > 0) begin
                        alarm_finished[i] = 1'b1;
                        hold[i]--;
                    end else if ($urandom_range(0, 39) == 0) begin
                        alarm_finished[i] = 1'b1;
                        hold[i] = 1;
                    end else begin
                        alarm_finished[i] = 1'b0;
                    end
                end
                evt_ready      = ($urandom_range(0, 99) < rdy_pct);
                alarm_mask     = ($urandom_range(0, 7) == 0) ? NA'($urandom) : '1;
                clear_overflow = ($urandom_range(0, 15) == 0);
                reset          = ($urandom_range(0, 499) == 0);
                step(1);
            end
        end

        reset = 0; alarm_finished = '0; alarm_mask = '1;
        clear_overflow = 0; evt_ready = 1;
        step(40);
        chk("final_empty", evt_count, 0);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
